// File: rtl/program_loader.sv
// Boot loader: assembles a length-prefixed byte stream into instruction
// words, writes them to imem, and releases cpu_rst once the program is in.
module program_loader #(
  parameter int instSize = 24,
  parameter int addrBits = 10,
  parameter int byteBits = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                byte_valid,
  input  logic [byteBits-1:0] byte_data,
  output logic                byte_ready,
  output logic                imem_we,
  output logic [addrBits-1:0] imem_addr,
  output logic [instSize-1:0] imem_wdata,
  output logic                cpu_rst,
  output logic                done,
  output logic                error,
  output logic [addrBits:0]   words_loaded
);

  localparam int BPW = instSize / byteBits;
  localparam int CW = $clog2(BPW + 1);
  localparam int unsigned DEPTH = 1 << addrBits;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, LOAD, DONE, ERROR
  } state_t;

  state_t r_state, w_next;

  logic [15:0]         r_len;
  logic [CW-1:0]       r_cnt;
  logic [instSize-1:0] r_asm;
  logic                r_we;
  logic [addrBits-1:0] r_addr;
  logic [instSize-1:0] r_wdata;
  logic [addrBits:0]   r_words;
  logic                r_done;
  logic                r_cpu_rst;
  logic                r_error;

  logic                w_acc;
  logic                w_last_byte;
  logic                w_last_word;
  logic                w_new_sess;
  logic [15:0]         w_len;
  logic [instSize-1:0] w_word;

  assign w_acc = byte_valid && byte_ready;
  assign w_len = {r_len[15:8], byte_data};
  assign w_word = {r_asm[instSize-byteBits-1:0], byte_data};
  assign w_last_byte = (r_state == LOAD) && w_acc
                    && (r_cnt == CW'(BPW - 1));
  assign w_last_word = w_last_byte
                    && (32'(r_words) + 32'd1 == 32'(r_len));
  assign w_new_sess = start && ((r_state == IDLE)
                    || (r_state == DONE) || (r_state == ERROR));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    byte_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (w_acc) w_next = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (w_acc) begin
          if (w_len == 16'd0) w_next = DONE;
          else if (32'(w_len) > DEPTH) w_next = ERROR;
          else w_next = LOAD;
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        if (w_last_word) w_next = DONE;
      end
      DONE: begin
        if (start) w_next = LEN_HI;
      end
      ERROR: begin
        if (start) w_next = LEN_HI;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_asm     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_words   <= '0;
      r_done    <= 1'b0;
      r_cpu_rst <= 1'b1;
      r_error   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_new_sess) begin
        r_words <= '0;
        r_cnt   <= '0;
      end
      if (r_state == LEN_HI && w_acc) r_len[15:8] <= byte_data;
      if (r_state == LEN_LO && w_acc) r_len[7:0] <= byte_data;
      if (r_state == LOAD && w_acc) begin
        if (w_last_byte) begin
          r_we    <= 1'b1;
          r_wdata <= w_word;
          r_addr  <= r_words[addrBits-1:0];
          r_words <= r_words + 1'b1;
          r_cnt   <= '0;
        end else begin
          r_asm <= w_word;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // Status follows the state one cycle late; a start in DONE drops it at once.
      r_done    <= (r_state == DONE) && (w_next == DONE);
      r_cpu_rst <= !((r_state == DONE) && (w_next == DONE));
      r_error   <= (r_state == ERROR) && (w_next == ERROR);
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_words;
  assign done         = r_done;
  assign cpu_rst      = r_cpu_rst;
  assign error        = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a cycle table for the basic load,
// then hand-written sequences for stalls, empty/oversize headers, abort, full depth.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [23:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [10:0] words_loaded;

  int n_tests = 0;
  int n_fail = 0;

  logic [9:0]  wa[$];
  logic [23:0] wd[$];

  program_loader #(.instSize(24), .addrBits(10), .byteBits(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       we;
    logic [9:0] addr;
    logic [23:0] wdata;
    logic [10:0] words;
    logic       done;
    logic       crst;
    logic       err;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data = b;
    @(negedge clk);
    while (!byte_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!byte_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got ready=0 required ready=1 byte %h", b);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    // rst st vl data | rdy we addr wdata words done crst err
    vt[0]  = '{1,1,0,8'h00, 0,0,10'd0,24'h0,11'd0,0,1,0};
    vt[1]  = '{1,1,0,8'h00, 0,0,10'd0,24'h0,11'd0,0,1,0};
    vt[2]  = '{1,1,0,8'h00, 0,0,10'd0,24'h0,11'd0,0,1,0};
    vt[3]  = '{0,1,0,8'h00, 0,0,10'd0,24'h0,11'd0,0,1,0};
    vt[4]  = '{0,0,1,8'h00, 1,0,10'd0,24'h0,11'd0,0,1,0};
    vt[5]  = '{0,0,1,8'h02, 1,0,10'd0,24'h0,11'd0,0,1,0};
    vt[6]  = '{0,0,1,8'h11, 1,0,10'd0,24'h0,11'd0,0,1,0};
    vt[7]  = '{0,0,1,8'h22, 1,0,10'd0,24'h0,11'd0,0,1,0};
    vt[8]  = '{0,0,1,8'h33, 1,0,10'd0,24'h0,11'd0,0,1,0};
    vt[9]  = '{0,0,1,8'hAA, 1,1,10'd0,24'h112233,11'd1,0,1,0};
    vt[10] = '{0,0,1,8'hBB, 1,0,10'd0,24'h0,11'd1,0,1,0};
    vt[11] = '{0,0,1,8'hCC, 1,0,10'd0,24'h0,11'd1,0,1,0};
    vt[12] = '{0,0,1,8'hFF, 0,1,10'd1,24'hAABBCC,11'd2,0,1,0};
    vt[13] = '{0,0,1,8'hFF, 0,0,10'd0,24'h0,11'd2,1,0,0};
    vt[14] = '{0,0,0,8'h00, 0,0,10'd0,24'h0,11'd2,1,0,0};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      logic [47:0] got, exp;
      rst = vt[i].rst;
      start = vt[i].start;
      byte_valid = vt[i].valid;
      byte_data = vt[i].data;
      @(negedge clk);
      got = {byte_ready, imem_we, words_loaded, done, cpu_rst, error,
             (vt[i].we ? imem_addr : 10'd0),
             (vt[i].we ? imem_wdata : 24'd0)};
      exp = {vt[i].ready, vt[i].we, vt[i].words, vt[i].done,
             vt[i].crst, vt[i].err, vt[i].addr, vt[i].wdata};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL vec%0d: got rdy=%b we=%b wl=%0d done=%b crst=%b err=%b a=%h d=%h required rdy=%b we=%b wl=%0d done=%b crst=%b err=%b a=%h d=%h",
          i, byte_ready, imem_we, words_loaded, done, cpu_rst, error,
          imem_addr, imem_wdata, vt[i].ready, vt[i].we, vt[i].words,
          vt[i].done, vt[i].crst, vt[i].err, vt[i].addr, vt[i].wdata);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    byte_valid = 1'b0;

    // Same stream with valid toggling every cycle
    wa.delete(); wd.delete();
    pulse_start();
    send(8'h00, 1); send(8'h02, 1);
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    send(8'hAA, 1); send(8'hBB, 1); send(8'hCC, 1);
    repeat (3) @(negedge clk);
    chk("toggle_we_count", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("toggle_w0", {wa[0], wd[0]}, {10'd0, 24'h112233});
      chk("toggle_w1", {wa[1], wd[1]}, {10'd1, 24'hAABBCC});
    end
    chk("toggle_words", 32'(words_loaded), 32'd2);
    chk("toggle_done", {done, cpu_rst}, 2'b10);
    @(posedge clk); #1;

    // Empty program
    wa.delete(); wd.delete();
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
    @(negedge clk);
    chk("zero_done_t1", {done, cpu_rst, byte_ready}, 3'b010);
    @(negedge clk);
    chk("zero_done_t2", {done, cpu_rst}, 2'b10);
    chk("zero_no_we", 32'(wa.size()), 32'd0);
    chk("zero_words", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;

    // Oversize header, then recovery by start
    pulse_start();
    send(8'h04, 0); send(8'h01, 0);
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (2) @(negedge clk);
    chk("err_flags", {error, cpu_rst, byte_ready, done}, 4'b1100);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    pulse_start();
    @(negedge clk);
    chk("err_clear", {error, byte_ready, cpu_rst}, 3'b011);
    @(posedge clk); #1;

    // Aborted session followed by a clean one-word load
    wa.delete(); wd.delete();
    send(8'h00, 0); send(8'h03, 0);
    send(8'h12, 0); send(8'h34, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state", {imem_we, byte_ready, cpu_rst, done},
        4'b0010);
    chk("abort_words", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0);
    repeat (3) @(negedge clk);
    chk("abort_we_count", 32'(wa.size()), 32'd1);
    if (wa.size() == 1)
      chk("abort_w0", {wa[0], wd[0]}, {10'd0, 24'hDEADBE});
    chk("abort_words1", 32'(words_loaded), 32'd1);
    chk("abort_done", {done, cpu_rst}, 2'b10);
    @(posedge clk); #1;

    // Full-depth program, N = 1024
    wa.delete(); wd.delete();
    pulse_start();
    send(8'h04, 0); send(8'h00, 0);
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] iv;
      iv = 16'(i);
      send(iv[15:8], 0);
      send(iv[7:0], 0);
      send(8'h77, 0);
    end
    repeat (3) @(negedge clk);
    chk("full_we_count", 32'(wa.size()), 32'd1024);
    begin
      int bad = 0;
      for (int i = 0; i < wa.size() && i < 1024; i++) begin
        logic [15:0] iv;
        iv = 16'(i);
        if (wa[i] !== 10'(i) || wd[i] !== {iv, 8'h77}) bad++;
      end
      chk("full_contents_bad", 32'(bad), 32'd0);
    end
    if (wa.size() == 1024)
      chk("full_last_addr", 32'(wa[1023]), 32'd1023);
    chk("full_words", 32'(words_loaded), 32'd1024);
    chk("full_done", {done, cpu_rst, error}, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
